// File: rtl/min_queue_sorted_array_pkg.sv
//==============================================================================
// Module  : min_queue_sorted_array_pkg
// Brief   : Shared types for the sorted-array min-priority queue: occupancy
//           state encodings, per-slot operation codes, default widths.
//           Optional feature macro: MIN_QUEUE_DROP_MAX_EN
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package min_queue_sorted_array_pkg;

    localparam int c_DEF_RECORD_WD = 48;
    localparam int c_DEF_KEY_WD    = 16;
    localparam int c_DEF_DEPTH     = 16;
    localparam int c_DEF_CNT_WD    = 5;

    // Occupancy state of the whole array; full/empty decode from it
    typedef enum logic [1:0] {
        MQ_ST_EMPTY   = 2'd0,
        MQ_ST_PARTIAL = 2'd1,
        MQ_ST_FULL    = 2'd2
    } occ_state_t;

    // What a slot loads on the next edge
    typedef enum logic [1:0] {
        CELL_HOLD       = 2'd0,
        CELL_SHIFT_UP   = 2'd1,   // take neighbour i-1
        CELL_SHIFT_DOWN = 2'd2,   // take neighbour i+1
        CELL_LOAD       = 2'd3    // take the incoming record
    } cell_op_t;

endpackage

`default_nettype wire

// File: rtl/min_queue_sorted_array_if.sv
//==============================================================================
// Module  : min_queue_sorted_array_if
// Brief   : Producer/scheduler-facing bus of the min-priority queue.
//           master = producer/scheduler side, slave = queue side.
//           Optional feature macro: MIN_QUEUE_DROP_MAX_EN (adds drop outputs)
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

interface min_queue_sorted_array_if #(
    parameter int RECORD_WD = 48,
    parameter int CNT_WD    = 5
);
    logic                 push;
    logic [RECORD_WD-1:0] push_record;
    logic                 push_ready;
    logic                 pop;
    logic [RECORD_WD-1:0] pop_record;
    logic                 min_valid;
    logic                 flush;
    logic [CNT_WD-1:0]    count;
    logic                 full;
    logic                 empty;
    logic                 overflow;
`ifdef MIN_QUEUE_DROP_MAX_EN
    logic                 drop_valid;
    logic [RECORD_WD-1:0] drop_record;
`endif

    modport master (
        output push, push_record, pop, flush,
        input  push_ready, pop_record, min_valid, count, full, empty, overflow
`ifdef MIN_QUEUE_DROP_MAX_EN
        , input drop_valid, drop_record
`endif
    );

    modport slave (
        input  push, push_record, pop, flush,
        output push_ready, pop_record, min_valid, count, full, empty, overflow
`ifdef MIN_QUEUE_DROP_MAX_EN
        , output drop_valid, drop_record
`endif
    );
endinterface

`default_nettype wire

// File: rtl/min_queue_sorted_array_cell.sv
//==============================================================================
// Module  : min_queue_sorted_array_cell
// Brief   : One slot of the sorted array (valid + record). Flags whether the
//           incoming key sorts strictly before its own key and loads from
//           itself, either neighbour or the incoming record as commanded.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module min_queue_sorted_array_cell
    import min_queue_sorted_array_pkg::*;
#(
    parameter int RECORD_WD = 48,
    parameter int KEY_WD    = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 clear,
    input  wire cell_op_t             op,
    input  wire logic                 prev_valid,
    input  wire logic [RECORD_WD-1:0] prev_record,
    input  wire logic                 next_valid,
    input  wire logic [RECORD_WD-1:0] next_record,
    input  wire logic [RECORD_WD-1:0] new_record,
    output logic                      valid,
    output logic [RECORD_WD-1:0]      record,
    output logic                      new_lt
);

    logic                 r_valid;
    logic [RECORD_WD-1:0] r_record;
    logic [KEY_WD-1:0]    w_new_key;
    logic [KEY_WD-1:0]    w_my_key;

    assign w_new_key = new_record[RECORD_WD-1 -: KEY_WD];
    assign w_my_key  = r_record[RECORD_WD-1 -: KEY_WD];

    // Strict compare: equal keys keep the new record behind, giving FIFO ties
    assign new_lt = r_valid && (w_new_key < w_my_key);
    assign valid  = r_valid;
    assign record = r_record;

    // Slot register: cleared by reset/flush, otherwise follows the commanded op
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_valid  <= 1'b0;
            r_record <= '0;
        end else begin
            case (op)
                CELL_SHIFT_UP: begin
                    r_valid  <= prev_valid;
                    r_record <= prev_record;
                end
                CELL_SHIFT_DOWN: begin
                    r_valid  <= next_valid;
                    r_record <= next_record;
                end
                CELL_LOAD: begin
                    r_valid  <= 1'b1;
                    r_record <= new_record;
                end
                default: begin
                    r_valid  <= r_valid;
                    r_record <= r_record;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/min_queue_sorted_array.sv
//==============================================================================
// Module  : min_queue_sorted_array
// Brief   : Register-based always-sorted min-priority queue. Slot 0 holds the
//           minimum-key record. Push, pop, push+pop and flush in one cycle.
//           Optional feature macro: MIN_QUEUE_DROP_MAX_EN (push when full
//           evicts the largest record instead of being refused).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module min_queue_sorted_array
    import min_queue_sorted_array_pkg::*;
#(
    parameter int RECORD_WD = c_DEF_RECORD_WD,
    parameter int KEY_WD    = c_DEF_KEY_WD,
    parameter int DEPTH     = c_DEF_DEPTH,
    parameter int CNT_WD    = c_DEF_CNT_WD
) (
    input  wire logic               clk,
    input  wire logic               rst,
    min_queue_sorted_array_if.slave mq
);

    // Neighbour chains padded with an empty slot at each end
    logic [DEPTH+1:0]     w_valid_ext;
    logic [RECORD_WD-1:0] w_rec_ext [DEPTH+2];
    logic [DEPTH-1:0]     w_lt;
    logic [DEPTH:0]       w_g;        // thermometer: new record goes at or before slot i
    logic [DEPTH-1:0]     w_g_prev;   // w_g shifted: value for slot i-1
    cell_op_t             w_op [DEPTH];

    occ_state_t           r_state;
    logic [CNT_WD-1:0]    r_count;
    logic                 r_overflow;
    logic [CNT_WD-1:0]    w_count_nxt;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_min_valid;
    logic                 w_pop_acc;
    logic                 w_push_ready;
    logic                 w_push_acc;
    logic                 w_grow;
    logic                 w_shrink;

    assign w_valid_ext[0]       = 1'b0;
    assign w_valid_ext[DEPTH+1] = 1'b0;
    assign w_rec_ext[0]         = '0;
    assign w_rec_ext[DEPTH+1]   = '0;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
        min_queue_sorted_array_cell #(
            .RECORD_WD (RECORD_WD),
            .KEY_WD    (KEY_WD)
        ) u_cell (
            .clk         (clk),
            .rst         (rst),
            .clear       (mq.flush),
            .op          (w_op[gi]),
            .prev_valid  (w_valid_ext[gi]),
            .prev_record (w_rec_ext[gi]),
            .next_valid  (w_valid_ext[gi+2]),
            .next_record (w_rec_ext[gi+2]),
            .new_record  (mq.push_record),
            .valid       (w_valid_ext[gi+1]),
            .record      (w_rec_ext[gi+1]),
            .new_lt      (w_lt[gi])
        );
    end

    assign w_full      = (r_state == MQ_ST_FULL);
    assign w_empty     = (r_state == MQ_ST_EMPTY);
    assign w_min_valid = w_valid_ext[1];
    assign w_pop_acc   = mq.pop && w_min_valid;

`ifdef MIN_QUEUE_DROP_MAX_EN
    assign w_push_ready = 1'b1;
`else
    assign w_push_ready = !w_full || w_pop_acc;
`endif
    assign w_push_acc = mq.push && w_push_ready;

    // Insert-position thermometer: empty slots and larger keys lie after the new record
    always_comb begin
        w_g[DEPTH] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            w_g[i] = !w_valid_ext[i+1] || w_lt[i];
        end
    end
    assign w_g_prev = {w_g[DEPTH-2:0], 1'b0};

    // Per-slot operation; with push+pop the array shifts down and inserts one slot earlier
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_op[i] = CELL_HOLD;
            if (w_push_acc && w_pop_acc) begin
                if (!w_g[i+1]) begin
                    w_op[i] = CELL_SHIFT_DOWN;
                end else if ((i == 0) || !w_g[i]) begin
                    w_op[i] = CELL_LOAD;
                end
            end else if (w_push_acc) begin
                if (w_g_prev[i]) begin
                    w_op[i] = CELL_SHIFT_UP;
                end else if (w_g[i]) begin
                    w_op[i] = CELL_LOAD;
                end
            end else if (w_pop_acc) begin
                w_op[i] = CELL_SHIFT_DOWN;
            end
        end
    end

    // A push into a full array (drop build) replaces a record, so count holds
    assign w_grow   = w_push_acc && !w_pop_acc && !w_full;
    assign w_shrink = w_pop_acc && !w_push_acc;

    always_comb begin
        w_count_nxt = r_count;
        if (w_grow) begin
            w_count_nxt = r_count + CNT_WD'(1);
        end else if (w_shrink) begin
            w_count_nxt = r_count - CNT_WD'(1);
        end
    end

    // Occupancy FSM, count and sticky overflow
    always_ff @(posedge clk) begin
        if (rst || mq.flush) begin
            r_state    <= MQ_ST_EMPTY;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (w_count_nxt == '0) begin
                r_state <= MQ_ST_EMPTY;
            end else if (w_count_nxt == CNT_WD'(DEPTH)) begin
                r_state <= MQ_ST_FULL;
            end else begin
                r_state <= MQ_ST_PARTIAL;
            end
`ifndef MIN_QUEUE_DROP_MAX_EN
            if (mq.push && !w_push_ready) begin
                r_overflow <= 1'b1;
            end
`endif
        end
    end

`ifdef MIN_QUEUE_DROP_MAX_EN
    logic                 r_drop_valid;
    logic [RECORD_WD-1:0] r_drop_record;

    // Eviction on a push into a full array: the old last slot, or the new record if it sorts last
    always_ff @(posedge clk) begin
        if (rst || mq.flush) begin
            r_drop_valid  <= 1'b0;
            r_drop_record <= '0;
        end else begin
            r_drop_valid <= mq.push && !w_pop_acc && w_full;
            if (mq.push && !w_pop_acc && w_full) begin
                r_drop_record <= w_g[DEPTH-1] ? w_rec_ext[DEPTH] : mq.push_record;
            end
        end
    end

    assign mq.drop_valid  = r_drop_valid;
    assign mq.drop_record = r_drop_record;
`endif

    assign mq.push_ready = w_push_ready;
    assign mq.pop_record = w_rec_ext[1];
    assign mq.min_valid  = w_min_valid;
    assign mq.count      = r_count;
    assign mq.full       = w_full;
    assign mq.empty      = w_empty;
    assign mq.overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_min_queue_sorted_array.sv
//==============================================================================
// Module  : tb_min_queue_sorted_array
// Brief   : Self-checking bench for min_queue_sorted_array (default build,
//           MIN_QUEUE_DROP_MAX_EN undefined). A queue-based model tracks the
//           sorted contents; directed scenarios pin it, random traffic follows.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_min_queue_sorted_array;

    localparam int RW    = 48;
    localparam int KW    = 16;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    min_queue_sorted_array_if #(.RECORD_WD(RW), .CNT_WD(CW)) mq ();

    min_queue_sorted_array #(
        .RECORD_WD (RW),
        .KEY_WD    (KW),
        .DEPTH     (DEPTH),
        .CNT_WD    (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mq  (mq)
    );

    logic [RW-1:0] model_q [$];
    bit            model_ov;
    int            n_vec;
    int            n_bad;
    int            serial;

    // Build a record with the given key and a unique payload
    function automatic logic [RW-1:0] mk(input logic [KW-1:0] k);
        serial = serial + 1;
        return {k, 32'(serial)};
    endfunction

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output with the model state
    task automatic compare();
        int sz;
        bit exp_ready;
        sz        = model_q.size();
        exp_ready = (sz < DEPTH) || (mq.pop && (sz > 0));
        chk("count",      RW'(mq.count),      RW'(sz));
        chk("empty",      RW'(mq.empty),      RW'(sz == 0));
        chk("full",       RW'(mq.full),       RW'(sz == DEPTH));
        chk("min_valid",  RW'(mq.min_valid),  RW'(sz > 0));
        chk("overflow",   RW'(mq.overflow),   RW'(model_ov));
        chk("push_ready", RW'(mq.push_ready), RW'(exp_ready));
        if (sz > 0) begin
            chk("pop_record", mq.pop_record, model_q[0]);
        end
    endtask

    // Apply the next edge's effect to the model
    task automatic model_step();
        int  sz;
        bit  ready;
        bit  pop_acc;
        bit  push_acc;
        int  pos;
        sz = model_q.size();
        if (rst || mq.flush) begin
            model_q.delete();
            model_ov = 1'b0;
        end else begin
            pop_acc  = mq.pop && (sz > 0);
            ready    = (sz < DEPTH) || pop_acc;
            push_acc = mq.push && ready;
            if (mq.push && !ready) model_ov = 1'b1;
            if (pop_acc) void'(model_q.pop_front());
            if (push_acc) begin
                pos = model_q.size();
                for (int j = 0; j < model_q.size(); j++) begin
                    if (model_q[j][RW-1 -: KW] > mq.push_record[RW-1 -: KW]) begin
                        pos = j;
                        break;
                    end
                end
                model_q.insert(pos, mq.push_record);
            end
        end
    endtask

    // One clock: drive at the falling edge, check, then advance the model
    task automatic cyc(input bit p, input logic [RW-1:0] r, input bit po, input bit fl, input bit rs);
        @(negedge clk);
        mq.push        = p;
        mq.push_record = r;
        mq.pop         = po;
        mq.flush       = fl;
        rst            = rs;
        #1;
        compare();
        model_step();
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_k(input logic [KW-1:0] k);
        cyc(1'b1, mk(k), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    logic [RW-1:0] rec_a;
    logic [RW-1:0] rec_b;

    initial begin
        int push_pct;
        int pop_pct;
        int kmax;
        logic [KW-1:0] k;

        n_vec    = 0;
        n_bad    = 0;
        serial   = 0;
        model_ov = 1'b0;
        mq.push        = 1'b0;
        mq.push_record = '0;
        mq.pop         = 1'b0;
        mq.flush       = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("rst_count",     RW'(mq.count),     RW'(0));
        chk("rst_empty",     RW'(mq.empty),     RW'(1));
        chk("rst_full",      RW'(mq.full),      RW'(0));
        chk("rst_min_valid", RW'(mq.min_valid), RW'(0));
        chk("rst_overflow",  RW'(mq.overflow),  RW'(0));

        // Keys 5,3,9 come out as 3,5,9
        push_k(16'd5);
        push_k(16'd3);
        push_k(16'd9);
        pop1();
        chk("t1_count", RW'(mq.count), RW'(3));
        chk("t1_key3",  RW'(mq.pop_record[RW-1 -: KW]), RW'(3));
        pop1();
        chk("t1_key5",  RW'(mq.pop_record[RW-1 -: KW]), RW'(5));
        pop1();
        chk("t1_key9",  RW'(mq.pop_record[RW-1 -: KW]), RW'(9));
        idle();
        chk("t1_empty", RW'(mq.empty), RW'(1));

        // Equal keys leave in arrival order
        rec_a = mk(16'd7);
        rec_b = mk(16'd7);
        cyc(1'b1, rec_a, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, rec_b, 1'b0, 1'b0, 1'b0);
        pop1();
        chk("t2_first_A", mq.pop_record, rec_a);
        pop1();
        chk("t2_second_B", mq.pop_record, rec_b);
        idle();

        // Fill with 1..16, then push 0 with pop while full
        for (int i = 1; i <= DEPTH; i++) push_k(16'(i));
        cyc(1'b1, mk(16'd0), 1'b1, 1'b0, 1'b0);
        chk("t3_ready_full_pop", RW'(mq.push_ready), RW'(1));
        idle();
        chk("t3_count", RW'(mq.count), RW'(16));
        chk("t3_key0",  RW'(mq.pop_record[RW-1 -: KW]), RW'(0));
        chk("t3_full",  RW'(mq.full), RW'(1));

        // Push into a full queue without pop is refused
        push_k(16'd20);
        chk("t4_ready", RW'(mq.push_ready), RW'(0));
        idle();
        chk("t4_overflow", RW'(mq.overflow), RW'(1));
        chk("t4_count",    RW'(mq.count),    RW'(16));
        chk("t4_key0",     RW'(mq.pop_record[RW-1 -: KW]), RW'(0));

        // Drain to 4 entries, then flush together with a push
        for (int i = 0; i < 12; i++) pop1();
        cyc(1'b1, mk(16'd2), 1'b0, 1'b1, 1'b0);
        chk("t5_count_before", RW'(mq.count), RW'(4));
        idle();
        chk("t5_count",     RW'(mq.count),     RW'(0));
        chk("t5_empty",     RW'(mq.empty),     RW'(1));
        chk("t5_min_valid", RW'(mq.min_valid), RW'(0));
        chk("t5_overflow",  RW'(mq.overflow),  RW'(0));

        // Reset in the middle of traffic
        for (int i = 0; i < 8; i++) push_k(16'(30 - i));
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("t6_count_before", RW'(mq.count), RW'(8));
        idle();
        chk("t6_count", RW'(mq.count), RW'(0));
        chk("t6_empty", RW'(mq.empty), RW'(1));
        chk("t6_minv",  RW'(mq.min_valid), RW'(0));
        push_k(16'd4);
        idle();
        chk("t6_count1", RW'(mq.count), RW'(1));
        chk("t6_key4",   RW'(mq.pop_record[RW-1 -: KW]), RW'(4));

        // Random traffic in phases of different push/pop pressure and key spread
        for (int c = 0; c < 4000; c++) begin
            case ((c / 400) % 4)
                0:       begin push_pct = 80; pop_pct = 20; end
                1:       begin push_pct = 50; pop_pct = 50; end
                2:       begin push_pct = 90; pop_pct = 60; end
                default: begin push_pct = 20; pop_pct = 80; end
            endcase
            kmax = (((c / 800) % 2) == 0) ? 7 : 65535;
            k = 16'($urandom_range(0, kmax));
            cyc(($urandom_range(0, 99) < push_pct) ? 1'b1 : 1'b0,
                mk(k),
                ($urandom_range(0, 99) < pop_pct) ? 1'b1 : 1'b0,
                ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
